// File: rtl/axi_r_buffer_pkg.sv
// axi_r_buffer_pkg: shared RRESP codes and packed-entry field offsets
// for the AXI R-channel elastic buffer. No ports.
package axi_r_buffer_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Entry layout, LSB first: id, user, data, last, resp.
    function automatic int unsigned user_lsb(input int unsigned id_w);
        return id_w;
    endfunction

    function automatic int unsigned data_lsb(input int unsigned id_w,
                                             input int unsigned user_w);
        return id_w + user_w;
    endfunction

    function automatic int unsigned last_bit(input int unsigned id_w,
                                             input int unsigned user_w,
                                             input int unsigned data_w);
        return id_w + user_w + data_w;
    endfunction

    function automatic int unsigned resp_lsb(input int unsigned id_w,
                                             input int unsigned user_w,
                                             input int unsigned data_w);
        return last_bit(id_w, user_w, data_w) + 1;
    endfunction

    function automatic int unsigned entry_width(input int unsigned id_w,
                                                input int unsigned user_w,
                                                input int unsigned data_w);
        return resp_lsb(id_w, user_w, data_w) + 2;
    endfunction

endpackage

// File: rtl/axi_buffer_fifo_mem.sv
// axi_buffer_fifo_mem: DEPTH x WIDTH storage, synchronous write and clear,
// asynchronous read. Ports: clk_i, clr_i, we_i/waddr_i/wdata_i, raddr_i/rdata_o.
module axi_buffer_fifo_mem #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned DEPTH      = 2,
    parameter int unsigned ADDR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk_i,
    input  logic                  clr_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [WIDTH-1:0]      wdata_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [WIDTH-1:0]      rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (we_i) begin
            mem_d[waddr_i] = wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            mem_q <= '{default: '0};
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/axi_r_buffer.sv
// axi_r_buffer: elastic FIFO on the AXI R channel (slave -> master).
// Ports: clk_i/rst_i (sync, active-high), test_en_i, slave_* R inputs with
// slave_ready_o, master_* R outputs with master_ready_i, usage_o, bursts_o.
// Define AXI_R_BUFFER_BURST_CNT_EN to build the complete-burst counter;
// otherwise bursts_o is tied to 0.
module axi_r_buffer #(
    parameter int unsigned ID_WIDTH     = 4,
    parameter int unsigned DATA_WIDTH   = 64,
    parameter int unsigned USER_WIDTH   = 1,
    parameter int unsigned BUFFER_DEPTH = 2
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              test_en_i,
    input  logic                              slave_valid_i,
    input  logic [DATA_WIDTH-1:0]             slave_data_i,
    input  logic [1:0]                        slave_resp_i,
    input  logic                              slave_last_i,
    input  logic [ID_WIDTH-1:0]               slave_id_i,
    input  logic [USER_WIDTH-1:0]             slave_user_i,
    output logic                              slave_ready_o,
    output logic                              master_valid_o,
    output logic [DATA_WIDTH-1:0]             master_data_o,
    output logic [1:0]                        master_resp_o,
    output logic                              master_last_o,
    output logic [ID_WIDTH-1:0]               master_id_o,
    output logic [USER_WIDTH-1:0]             master_user_o,
    input  logic                              master_ready_i,
    output logic [$clog2(BUFFER_DEPTH+1)-1:0] usage_o,
    output logic [$clog2(BUFFER_DEPTH+1)-1:0] bursts_o
);

    import axi_r_buffer_pkg::*;

    localparam int unsigned CW = $clog2(BUFFER_DEPTH + 1);
    localparam int unsigned PW = (BUFFER_DEPTH > 1) ? $clog2(BUFFER_DEPTH) : 1;
    localparam int unsigned EW = entry_width(ID_WIDTH, USER_WIDTH, DATA_WIDTH);
    localparam int unsigned U_LSB = user_lsb(ID_WIDTH);
    localparam int unsigned D_LSB = data_lsb(ID_WIDTH, USER_WIDTH);
    localparam int unsigned L_BIT = last_bit(ID_WIDTH, USER_WIDTH, DATA_WIDTH);
    localparam int unsigned R_LSB = resp_lsb(ID_WIDTH, USER_WIDTH, DATA_WIDTH);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          full, empty, push, pop;
    logic [EW-1:0] wr_entry, rd_entry, head;
    logic          unused_test_en;

    assign unused_test_en = test_en_i;

    function automatic logic [PW-1:0] inc_ptr(input logic [PW-1:0] p);
        return (p == PW'(BUFFER_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full  = (count_q == CW'(BUFFER_DEPTH));
    assign empty = (count_q == '0);

    // Handshakes depend on registered count only, so there is no
    // combinational path from master_ready_i to slave_ready_o.
    assign slave_ready_o  = !rst_i && !full;
    assign master_valid_o = !rst_i && !empty;
    assign push = slave_valid_i && slave_ready_o;
    assign pop  = master_valid_o && master_ready_i;

    assign wr_entry = {slave_resp_i, slave_last_i, slave_data_i,
                       slave_user_i, slave_id_i};

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = inc_ptr(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = inc_ptr(rd_ptr_q);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    axi_buffer_fifo_mem #(
        .WIDTH      (EW),
        .DEPTH      (BUFFER_DEPTH),
        .ADDR_WIDTH (PW)
    ) u_mem (
        .clk_i   (clk_i),
        .clr_i   (rst_i),
        .we_i    (push),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_entry),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_entry)
    );

    // Storage is only cleared at the reset edge, so mask outputs while
    // rst_i is high.
    assign head = rst_i ? '0 : rd_entry;

    assign master_id_o   = head[ID_WIDTH-1:0];
    assign master_user_o = head[U_LSB +: USER_WIDTH];
    assign master_data_o = head[D_LSB +: DATA_WIDTH];
    assign master_last_o = head[L_BIT];
    assign master_resp_o = head[R_LSB +: 2];
    assign usage_o       = rst_i ? '0 : count_q;

`ifdef AXI_R_BUFFER_BURST_CNT_EN
    logic [CW-1:0] bursts_q, bursts_d;
    logic          push_last, pop_last;

    assign push_last = push && slave_last_i;
    assign pop_last  = pop && rd_entry[L_BIT];

    always_comb begin
        bursts_d = bursts_q;
        unique case ({push_last, pop_last})
            2'b10:   bursts_d = bursts_q + CW'(1);
            2'b01:   bursts_d = bursts_q - CW'(1);
            default: bursts_d = bursts_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bursts_q <= '0;
        end else begin
            bursts_q <= bursts_d;
        end
    end

    assign bursts_o = rst_i ? '0 : bursts_q;
`else
    assign bursts_o = '0;
`endif

endmodule
